// File: rtl/fp_multiplier_pipe_if.sv
// Operand/result handshake bundle for fp_multiplier_pipe.
// master: operand issuer and result consumer. slave: the multiplier.
// Signals: in_valid/in_ready/number_1/number_2 (operand side), out_valid/out_ready/number_out/flags (result side).
interface fp_multiplier_pipe_if #(
    parameter int D_WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [D_WIDTH-1:0] number_1;
    logic [D_WIDTH-1:0] number_2;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] number_out;
    logic [3:0]         flags;      // {invalid, overflow, underflow, inexact}

    modport master (
        output in_valid, number_1, number_2, out_ready,
        input  in_ready, out_valid, number_out, flags
    );

    modport slave (
        input  in_valid, number_1, number_2, out_ready,
        output in_ready, out_valid, number_out, flags
    );
endinterface

// File: rtl/fp_multiplier_pipe.sv
// Pipelined IEEE-754 multiplier (RNE, flush-to-zero, zero/Inf/NaN handling, exception flags).
// Latency: 3 register stages; out_valid rises on the 3rd rising edge counting the accept edge.
// Backpressure: in_ready = !(out_valid && !out_ready); a stalled output freezes every stage.
// Ports: clk, rst (async active-high), bus (slave modport: operands in, product + flags out).
module fp_multiplier_pipe #(
    parameter int E_WIDTH = 8,   // >= 3
    parameter int M_WIDTH = 23,  // >= 2
    parameter int D_WIDTH = 32   // == 1 + E_WIDTH + M_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_multiplier_pipe_if.slave   bus
);
    localparam int P_WIDTH = 2*M_WIDTH + 2;
    localparam int X_WIDTH = E_WIDTH + 2;   // signed working exponent
    localparam int BIAS_I  = (1 << (E_WIDTH-1)) - 1;
    localparam logic [E_WIDTH-1:0]        EMAX   = '1;
    localparam logic signed [X_WIDTH-1:0] BIAS   = BIAS_I[X_WIDTH-1:0];
    localparam logic signed [X_WIDTH-1:0] EMAX_S = {2'b00, EMAX};
    localparam logic signed [X_WIDTH-1:0] ZERO_S = '0;
    localparam logic [D_WIDTH-1:0]        QNAN   = {1'b0, EMAX, 1'b1, {(M_WIDTH-1){1'b0}}};

    // Result class decided in S1 and carried down the pipe
    localparam logic [1:0] SP_NORM = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    // Whole pipe advances together; no bubble collapse.
    logic r_out_valid;
    logic w_adv;
    assign w_adv        = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready = !rst && w_adv;

    // ---------------- S1: unpack / classify ----------------
    logic               w_sa, w_sb;
    logic [E_WIDTH-1:0] w_ea, w_eb;
    logic [M_WIDTH-1:0] w_fa, w_fb;
    logic w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_inf_x_zero;
    logic [1:0] w_spec1;
    logic       w_inv1;
    logic signed [X_WIDTH-1:0] w_exp1;

    assign {w_sa, w_ea, w_fa} = bus.number_1;
    assign {w_sb, w_eb, w_fb} = bus.number_2;
    // exp==0 covers both true zero and subnormals (flushed)
    assign w_za = (w_ea == '0);
    assign w_zb = (w_eb == '0);
    assign w_ia = (w_ea == EMAX) && (w_fa == '0);
    assign w_ib = (w_eb == EMAX) && (w_fb == '0);
    assign w_na = (w_ea == EMAX) && (w_fa != '0);
    assign w_nb = (w_eb == EMAX) && (w_fb != '0);
    assign w_inf_x_zero = (w_ia && w_zb) || (w_za && w_ib);
    assign w_exp1 = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

    always_comb begin
        w_spec1 = SP_NORM;
        if (w_na || w_nb || w_inf_x_zero) w_spec1 = SP_NAN;
        else if (w_ia || w_ib)            w_spec1 = SP_INF;
        else if (w_za || w_zb)            w_spec1 = SP_ZERO;
    end
    // Signalling NaN has the fraction MSB clear
    assign w_inv1 = w_inf_x_zero || (w_na && !w_fa[M_WIDTH-1]) || (w_nb && !w_fb[M_WIDTH-1]);

    logic                      r_v1, r_sign1, r_inv1;
    logic [1:0]                r_spec1;
    logic signed [X_WIDTH-1:0] r_exp1;
    logic [M_WIDTH:0]          r_ma1, r_mb1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0; r_sign1 <= 1'b0; r_inv1 <= 1'b0; r_spec1 <= SP_NORM;
            r_exp1 <= '0; r_ma1 <= '0; r_mb1 <= '0;
        end else if (w_adv) begin
            r_v1    <= bus.in_valid;
            r_sign1 <= w_sa ^ w_sb;
            r_inv1  <= w_inv1;
            r_spec1 <= w_spec1;
            r_exp1  <= w_exp1;
            r_ma1   <= {1'b1, w_fa};
            r_mb1   <= {1'b1, w_fb};
        end
    end

    // ---------------- S2: mantissa multiply ----------------
    logic                      r_v2, r_sign2, r_inv2;
    logic [1:0]                r_spec2;
    logic signed [X_WIDTH-1:0] r_exp2;
    logic [P_WIDTH-1:0]        r_prod2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2 <= 1'b0; r_sign2 <= 1'b0; r_inv2 <= 1'b0; r_spec2 <= SP_NORM;
            r_exp2 <= '0; r_prod2 <= '0;
        end else if (w_adv) begin
            r_v2    <= r_v1;
            r_sign2 <= r_sign1;
            r_inv2  <= r_inv1;
            r_spec2 <= r_spec1;
            r_exp2  <= r_exp1;
            r_prod2 <= {{(M_WIDTH+1){1'b0}}, r_ma1} * {{(M_WIDTH+1){1'b0}}, r_mb1};
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    // Product is in [1,4); w_norm drops the hidden bit so its MSB is the first fraction bit.
    logic [P_WIDTH-2:0]        w_norm;
    logic signed [X_WIDTH-1:0] w_exp_n, w_exp_f;
    logic [M_WIDTH-1:0]        w_frac, w_frac_r;
    logic                      w_guard, w_round, w_sticky, w_inc, w_carry, w_inexact;
    logic [D_WIDTH-1:0]        w_res;
    logic [3:0]                w_flg;

    assign w_norm   = r_prod2[P_WIDTH-1] ? r_prod2[P_WIDTH-2:0] : {r_prod2[P_WIDTH-3:0], 1'b0};
    assign w_exp_n  = r_exp2 + $signed({{(X_WIDTH-1){1'b0}}, r_prod2[P_WIDTH-1]});
    assign w_frac   = w_norm[P_WIDTH-2 -: M_WIDTH];
    assign w_guard  = w_norm[M_WIDTH];
    assign w_round  = w_norm[M_WIDTH-1];
    assign w_sticky = |w_norm[M_WIDTH-2:0];
    assign w_inc    = w_guard && (w_round || w_sticky || w_frac[0]);
    // Carry out leaves the fraction at zero, i.e. mantissa 1.0 one binade up
    assign {w_carry, w_frac_r} = {1'b0, w_frac} + {{M_WIDTH{1'b0}}, w_inc};
    assign w_exp_f   = w_exp_n + $signed({{(X_WIDTH-1){1'b0}}, w_carry});
    assign w_inexact = w_guard || w_round || w_sticky;

    always_comb begin
        w_res = '0;
        w_flg = 4'b0000;
        case (r_spec2)
            SP_NAN: begin
                w_res = QNAN;
                w_flg = {r_inv2, 3'b000};
            end
            SP_INF:  w_res = {r_sign2, EMAX, {M_WIDTH{1'b0}}};
            SP_ZERO: w_res = {r_sign2, {(D_WIDTH-1){1'b0}}};
            default: begin
                if (w_exp_f >= EMAX_S) begin
                    w_res = {r_sign2, EMAX, {M_WIDTH{1'b0}}};
                    w_flg = 4'b0101;
                end else if (w_exp_f <= ZERO_S) begin
                    w_res = {r_sign2, {(D_WIDTH-1){1'b0}}};
                    w_flg = 4'b0011;
                end else begin
                    w_res = {r_sign2, w_exp_f[E_WIDTH-1:0], w_frac_r};
                    w_flg = {3'b000, w_inexact};
                end
            end
        endcase
    end

    logic [D_WIDTH-1:0] r_number_out;
    logic [3:0]         r_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_number_out <= '0;
            r_flags      <= 4'b0000;
        end else if (w_adv) begin
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_number_out <= w_res;
                r_flags      <= w_flg;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.number_out = r_number_out;
    assign bus.flags      = r_flags;
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
module tb_fp_multiplier_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_multiplier_pipe_if #(.D_WIDTH(32)) s();
    fp_multiplier_pipe_if #(.D_WIDTH(64)) d();

    fp_multiplier_pipe #(.E_WIDTH(8),  .M_WIDTH(23), .D_WIDTH(32)) dut_s (.clk(clk), .rst(rst), .bus(s));
    fp_multiplier_pipe #(.E_WIDTH(11), .M_WIDTH(52), .D_WIDTH(64)) dut_d (.clk(clk), .rst(rst), .bus(d));

    typedef struct packed {
        logic [3:0]  f;
        logic [31:0] r;
    } res_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Single-precision reference: exact integer product, rounded by remainder vs half-ulp.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic s_o, na, nb, ia, ib, za, zb;
        int ea, eb, ex, sh;
        longint unsigned ma, mb, prod, q, rem, half;
        s_o = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        r.f = 4'b0000;
        r.r = 32'h0;
        if (na || nb || (ia && zb) || (za && ib)) begin
            r.r    = 32'h7FC00000;
            r.f[3] = (ia && zb) || (za && ib) || (na && !a[22]) || (nb && !b[22]);
            return r;
        end
        if (ia || ib) begin
            r.r = {s_o, 8'hFF, 23'h0};
            return r;
        end
        if (za || zb) begin
            r.r = {s_o, 31'h0};
            return r;
        end
        ma   = 64'h80_0000 + 64'(a[22:0]);
        mb   = 64'h80_0000 + 64'(b[22:0]);
        prod = ma * mb;
        ex   = ea + eb - 127;
        sh   = 23;
        if (prod >= 64'h8000_0000_0000) begin
            sh = 24;
            ex++;
        end
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == 64'h100_0000) begin
            q = 64'h80_0000;
            ex++;
        end
        if (ex >= 255) begin
            r.r = {s_o, 8'hFF, 23'h0};
            r.f = 4'b0101;
        end else if (ex <= 0) begin
            r.r = {s_o, 31'h0};
            r.f = 4'b0011;
        end else begin
            r.r = {s_o, ex[7:0], q[22:0]};
            r.f = {3'b000, rem != 0};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [31:0] v;
        logic [7:0]  e;
        k = $urandom_range(0, 11);
        v = $urandom;
        e = 8'($urandom_range(60, 190));
        case (k)
            0:       v = 32'h0000_0000;
            1:       v = 32'h7F80_0000;
            2:       v = 32'h7FC0_0000;
            3:       v = 32'h7F80_0005;
            4:       v = 32'h0000_0123;
            default: v = {v[31], e, v[22:0]};
        endcase
        return v;
    endfunction

    // One isolated operation with out_ready held high; latency counted in edges incl. the accept edge.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        s.in_valid = 1'b1; s.number_1 = a; s.number_2 = b; s.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(s.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        s.in_valid = 1'b0;
        lat = 1;
        while (!s.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd3);
        chk({tag, "_result"}, 64'(s.number_out), 64'(er));
        chk({tag, "_flags"}, 64'(s.flags), 64'(ef));
    endtask

    initial begin
        int sent, got, cyc, lat;
        logic [31:0] ra[8], rb[8];
        logic held_v;
        logic [31:0] held_r;
        logic [3:0]  held_f;
        res_t e;

        rst = 1'b1;
        s.in_valid = 1'b0; s.number_1 = '0; s.number_2 = '0; s.out_ready = 1'b1;
        d.in_valid = 1'b0; d.number_1 = '0; d.number_2 = '0; d.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(s.out_valid), 64'd0);
        chk("reset_number_out", 64'(s.number_out), 64'd0);
        chk("reset_flags", 64'(s.flags), 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 64'(s.in_ready), 64'd1);

        // Directed cases
        run_one("mul_norm", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        run_one("mul_sign", 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
        run_one("rnd_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_one("exact_one", 32'h3F800000, 32'h3F800001, 32'h3F800001, 4'b0000);
        run_one("tie_up_odd", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
        run_one("tie_keep_even", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);
        run_one("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
        run_one("underflow_p", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        run_one("underflow_n", 32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011);
        run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_one("ninf_x_two", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        run_one("qnan", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
        run_one("snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_one("subnormal", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);

        // Random stream with random backpressure, checked in order against the model
        for (int i = 0; i < 8; i++) begin
            ra[i] = rand_op();
            rb[i] = rand_op();
        end
        sent = 0; got = 0; cyc = 0; held_v = 1'b0; held_r = '0; held_f = '0;
        @(negedge clk);
        while (got < 8 && cyc < 400) begin
            s.out_ready = ($urandom_range(0, 2) != 0);
            s.in_valid  = (sent < 8);
            if (sent < 8) begin
                s.number_1 = ra[sent];
                s.number_2 = rb[sent];
            end
            #1;
            chk("bp_in_ready", 64'(s.in_ready), 64'(!(s.out_valid && !s.out_ready)));
            if (held_v) begin
                chk("bp_hold_valid", 64'(s.out_valid), 64'd1);
                chk("bp_hold_result", 64'(s.number_out), 64'(held_r));
                chk("bp_hold_flags", 64'(s.flags), 64'(held_f));
            end
            if (s.out_valid && s.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp_unexpected_out", 64'(s.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bp_result", 64'(s.number_out), 64'(e.r));
                    chk("bp_flags", 64'(s.flags), 64'(e.f));
                    got++;
                end
            end
            held_v = s.out_valid && !s.out_ready;
            held_r = s.number_out;
            held_f = s.flags;
            if (s.in_valid && s.in_ready) begin
                exp_q.push_back(model(ra[sent], rb[sent]));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        s.in_valid = 1'b0;
        s.out_ready = 1'b1;
        chk("bp_received", 64'(got), 64'd8);
        repeat (5) begin
            @(negedge clk);
            chk("bp_no_duplicate", 64'(s.out_valid), 64'd0);
        end

        // Reset with three results in flight (first already at the output)
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s.in_valid = 1'b1; s.number_1 = 32'h3FC00000; s.number_2 = 32'h40000000;
        end
        @(negedge clk);
        s.in_valid = 1'b0;
        s.out_ready = 1'b0;
        chk("rst_pre_valid", 64'(s.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(s.out_valid), 64'd0);
        chk("rst_number_out", 64'(s.number_out), 64'd0);
        chk("rst_flags", 64'(s.flags), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s.out_ready = 1'b1;
        #1;
        chk("rst_release_in_ready", 64'(s.in_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(s.out_valid), 64'd0);
        end

        // Double-precision instance
        @(negedge clk);
        d.in_valid = 1'b1; d.number_1 = 64'h3FF8000000000000; d.number_2 = 64'h4000000000000000;
        #1;
        chk("dp_in_ready", 64'(d.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        d.in_valid = 1'b0;
        lat = 1;
        while (!d.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("dp_latency", 64'(lat), 64'd3);
        chk("dp_result", d.number_out, 64'h4008000000000000);
        chk("dp_flags", 64'(d.flags), 64'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
